// File: rtl/fifo_dp_ctrl_pkg.sv
// Shared helpers for the dual-port FIFO controller: ceiling log2 for sizing
// address, occupancy and level fields.
package fifo_dp_ctrl_pkg;

    // Number of bits needed to encode values 0..n-1 (ceiling log2).
    function automatic int log2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ctrl_obuf.sv
// Two-entry output buffer holding prefetched RAM words; head entry is a
// register so the consumer sees registered data.
module fifo_ctrl_obuf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    // Callers never write into a full buffer nor read from an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (wr_en) begin
                        slot0 <= wr_data;
                        cnt   <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({wr_en, rd_en})
                        2'b10: begin
                            slot1 <= wr_data;
                            cnt   <= 2'd2;
                        end
                        2'b01: cnt   <= 2'd0;
                        2'b11: slot0 <= wr_data;
                        default: ;
                    endcase
                end
                default: begin
                    if (rd_en) begin
                        slot0 <= slot1;
                        if (wr_en)
                            slot1 <= wr_data;
                        else
                            cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign head_data = slot0;

endmodule

// File: rtl/fifo_dp_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM (A write, B read,
// 1-cycle registered read). Optional `level` port enabled by FIFO_CTRL_LEVEL_EN.
module fifo_dp_ctrl
    import fifo_dp_ctrl_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = log2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [WIDTH-1:0]      ram_dina,
    output logic                  ram_ena,
    output logic                  ram_wra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_wrb,
    input  logic [WIDTH-1:0]      ram_doutb
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [log2(DEPTH+3)-1:0] level
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]      ram_cnt;
    logic [CNT_W-1:0]      ram_cnt_nxt;
    logic                  inflight;
    logic                  in_ready_r;
    logic [1:0]            obuf_cnt;
    logic [2:0]            pending;
    logic                  push;
    logic                  pop;
    logic                  issue;

    assign push = in_valid && in_ready_r;
    assign pop  = out_valid && out_ready;

    // Words that will occupy the buffer once this cycle's pop retires; counting
    // the pop lets a read issue every cycle while the consumer keeps draining.
    assign pending = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
    assign issue   = (ram_cnt != '0) && (pending < 3'd2);

    assign ram_cnt_nxt = ram_cnt + CNT_W'(push) - CNT_W'(issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            inflight   <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + ADDR_WIDTH'(1);
            if (issue)
                rptr <= rptr + ADDR_WIDTH'(1);
            ram_cnt    <= ram_cnt_nxt;
            inflight   <= issue;
            in_ready_r <= (ram_cnt_nxt < DEPTH_C);
        end
    end

    // RAM port A: write on accepted push; data gated so idle/reset cycles drive 0.
    assign ram_ena   = push;
    assign ram_wra   = push;
    assign ram_addra = wptr;
    assign ram_dina  = push ? in_data : '0;

    // RAM port B: read-only; rptr never equals wptr on a push because ram_cnt > 0.
    assign ram_enb   = issue;
    assign ram_wrb   = 1'b0;
    assign ram_addrb = rptr;

    fifo_ctrl_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (inflight),
        .wr_data   (ram_doutb),
        .rd_en     (pop),
        .head_data (out_data),
        .cnt       (obuf_cnt)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = (obuf_cnt != 2'd0);

`ifdef FIFO_CTRL_LEVEL_EN
    localparam int LVL_W = log2(DEPTH + 3);

    logic [LVL_W-1:0] level_r;

    // ram_cnt + inflight + obuf_cnt changes only on push (+1) and pop (-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_r <= '0;
        else
            level_r <= level_r + LVL_W'(push) - LVL_W'(pop);
    end

    assign level = level_r;
`endif

endmodule
